// File: rtl/mips_defs.sv
// Shared opcode, ALU-control and control-bundle definitions for the decode stage.
package mips_defs;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned NREGS   = 32;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned FUNCT_W = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADD   = 6'b010000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

   localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_IMM    = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;

   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0010;
   localparam logic [FUNCT_W-1:0] FUNCT_CMP = 4'b0100;

   // Control bundle carried through ID/EX
   typedef struct packed {
      logic               alu_src;
      logic               branch;
      logic               reg_dst;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic [ALUOP_W-1:0] alu_op;
      logic [FUNCT_W-1:0] funct_c;
      logic               illegal;
   } ctrl_t;

   // Opcode to control mapping; unknown opcodes yield all-zero controls plus illegal
   function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op,
                                         input logic [FUNCT_W-1:0] funct_lo);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_RTYPE;
            c.funct_c   = funct_lo;
         end
         OP_ADD: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_IMM;
            c.funct_c   = FUNCT_ADD;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.alu_op     = ALUOP_IMM;
            c.funct_c    = FUNCT_ADD;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            c.alu_op    = ALUOP_IMM;
            c.funct_c   = FUNCT_ADD;
         end
         OP_BEQ: begin
            c.branch  = 1'b1;
            c.alu_op  = ALUOP_BRANCH;
            c.funct_c = FUNCT_CMP;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   // Opcodes whose rt field is a source operand
   function automatic logic reads_rt(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports with write-through, one sync write port, sync clear.
module reg_file
   import mips_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1_c,
   output logic [XLEN-1:0]   rdata2_c
);

   logic [XLEN-1:0] mem [NREGS];
   logic            wr_ok_c;

   assign wr_ok_c = we && (waddr != '0);

   // Storage: clear on reset, r0 never written
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok_c) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports: r0 is hard zero, a same-cycle write is forwarded
   always_comb begin
      rdata1_c = mem[raddr1];
      rdata2_c = mem[raddr2];
      if (wr_ok_c && (waddr == raddr1)) rdata1_c = wdata;
      if (wr_ok_c && (waddr == raddr2)) rdata2_c = wdata;
      if (raddr1 == '0) rdata1_c = '0;
      if (raddr2 == '0) rdata2_c = '0;
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode, operand read, load-use detection and the ID/EX pipeline register.
module decode_stage
   import mips_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [XLEN-1:0]    instruct,
   input  logic [XLEN-1:0]    address,
   input  logic               valid_in,
   input  logic               stall,
   input  logic               flush,
   input  logic               wb_reg_write,
   input  logic [REG_AW-1:0]  wb_reg,
   input  logic [XLEN-1:0]    wb_data,
   output logic               hazard_stall,
   output logic [XLEN-1:0]    mem1Read,
   output logic [XLEN-1:0]    mem2Read,
   output logic [XLEN-1:0]    signExnd,
   output logic [XLEN-1:0]    address_ex,
   output logic [XLEN-1:0]    instruct_ex,
   output logic [REG_AW-1:0]  rt_ex,
   output logic [REG_AW-1:0]  rd_ex,
   output logic               ALUSrc,
   output logic               Branch,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [FUNCT_W-1:0] FunctC,
   output logic               valid_ex,
   output logic               illegal_op
);

   logic [OP_W-1:0]   opcode_c;
   logic [REG_AW-1:0] rs_c;
   logic [REG_AW-1:0] rt_c;
   logic [XLEN-1:0]   rs_val_c;
   logic [XLEN-1:0]   rt_val_c;
   logic [XLEN-1:0]   imm_ext_c;
   ctrl_t             ctrl_c;
   ctrl_t             ctrl_ex;
   logic              load_c;
   logic              bubble_c;

   assign opcode_c  = instruct[31:26];
   assign rs_c      = instruct[25:21];
   assign rt_c      = instruct[20:16];
   assign imm_ext_c = {{16{instruct[15]}}, instruct[15:0]};

   reg_file u_reg_file (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wb_reg_write),
      .waddr    (wb_reg),
      .wdata    (wb_data),
      .raddr1   (rs_c),
      .raddr2   (rt_c),
      .rdata1_c (rs_val_c),
      .rdata2_c (rt_val_c)
   );

   // Decode; an empty slot carries no controls and is never flagged illegal
   always_comb begin
      ctrl_c = '0;
      if (valid_in) ctrl_c = decode_ctrl(opcode_c, instruct[3:0]);
   end

   // Load-use: the load in EX targets a register this instruction reads
   always_comb begin
      hazard_stall = 1'b0;
      if (valid_in && valid_ex && ctrl_ex.mem_read && (rt_ex != '0)) begin
         hazard_stall = (rt_ex == rs_c) || ((rt_ex == rt_c) && reads_rt(opcode_c));
      end
   end

   // flush overrides stall; a hazard only bubbles when not held
   assign load_c   = flush || !stall;
   assign bubble_c = flush || hazard_stall;

   // ID/EX register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem1Read    <= '0;
         mem2Read    <= '0;
         signExnd    <= '0;
         address_ex  <= RESET_PC;
         instruct_ex <= '0;
         rt_ex       <= '0;
         rd_ex       <= '0;
         ctrl_ex     <= '0;
         valid_ex    <= 1'b0;
      end else if (load_c) begin
         mem1Read    <= rs_val_c;
         mem2Read    <= rt_val_c;
         signExnd    <= imm_ext_c;
         address_ex  <= address;
         instruct_ex <= instruct;
         rt_ex       <= rt_c;
         rd_ex       <= instruct[15:11];
         if (bubble_c) begin
            ctrl_ex  <= '0;
            valid_ex <= 1'b0;
         end else begin
            ctrl_ex  <= ctrl_c;
            valid_ex <= valid_in;
         end
      end
   end

   assign ALUSrc     = ctrl_ex.alu_src;
   assign Branch     = ctrl_ex.branch;
   assign RegDst     = ctrl_ex.reg_dst;
   assign RegWrite   = ctrl_ex.reg_write;
   assign MemRead    = ctrl_ex.mem_read;
   assign MemWrite   = ctrl_ex.mem_write;
   assign MemtoReg   = ctrl_ex.mem_to_reg;
   assign ALUOp      = ctrl_ex.alu_op;
   assign FunctC     = ctrl_ex.funct_c;
   assign illegal_op = ctrl_ex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: behavioural model, per-cycle compare, directed and random stimulus.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruct, address, wb_data;
   logic        valid_in, stall, flush, wb_reg_write;
   logic [4:0]  wb_reg;
   logic        hazard_stall;
   logic [31:0] mem1Read, mem2Read, signExnd, address_ex, instruct_ex;
   logic [4:0]  rt_ex, rd_ex;
   logic        ALUSrc, Branch, RegDst, RegWrite, MemRead, MemWrite, MemtoReg;
   logic [1:0]  ALUOp;
   logic [3:0]  FunctC;
   logic        valid_ex, illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .instruct(instruct), .address(address),
      .valid_in(valid_in), .stall(stall), .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
      .hazard_stall(hazard_stall), .mem1Read(mem1Read), .mem2Read(mem2Read),
      .signExnd(signExnd), .address_ex(address_ex), .instruct_ex(instruct_ex),
      .rt_ex(rt_ex), .rd_ex(rd_ex), .ALUSrc(ALUSrc), .Branch(Branch),
      .RegDst(RegDst), .RegWrite(RegWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
      .FunctC(FunctC), .valid_ex(valid_ex), .illegal_op(illegal_op)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Controls packed as {alusrc,branch,regdst,regwrite,memread,memwrite,memtoreg,aluop[1:0],funct[3:0],illegal}
   logic [31:0] m_rf [32];
   logic [31:0] m_m1, m_m2, m_sx, m_addr, m_instr;
   logic [4:0]  m_rt, m_rd;
   logic [13:0] m_ctl;
   logic        m_valid;
   logic        m_hz;

   function automatic logic [13:0] ref_decode(input logic [31:0] ins);
      case (ins[31:26])
         6'h00:   return {7'b0011000, 2'b10, ins[3:0], 1'b0};
         6'h10:   return {7'b1001000, 2'b01, 4'b0010, 1'b0};
         6'h23:   return {7'b1001101, 2'b01, 4'b0010, 1'b0};
         6'h2B:   return {7'b1000010, 2'b01, 4'b0010, 1'b0};
         6'h04:   return {7'b0100000, 2'b00, 4'b0100, 1'b0};
         default: return {13'b0, 1'b1};
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wb_reg_write && wb_reg == r) return wb_data;
      return m_rf[r];
   endfunction

   function automatic logic ref_hazard();
      logic [5:0] op;
      logic       uses_rt;
      op = instruct[31:26];
      uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      // m_ctl[9] is the MemRead bit of the model's packed controls
      return valid_in && m_valid && m_ctl[9] && (m_rt != 5'd0) &&
             ((m_rt == instruct[25:21]) || (m_rt == instruct[20:16] && uses_rt));
   endfunction

   // Model update on each rising edge
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
         m_m1 = 0; m_m2 = 0; m_sx = 0; m_addr = 32'h0; m_instr = 0;
         m_rt = 0; m_rd = 0; m_ctl = 0; m_valid = 0;
      end else begin
         m_hz = ref_hazard();
         if (flush || !stall) begin
            m_m1    = ref_read(instruct[25:21]);
            m_m2    = ref_read(instruct[20:16]);
            m_sx    = {{16{instruct[15]}}, instruct[15:0]};
            m_addr  = address;
            m_instr = instruct;
            m_rt    = instruct[20:16];
            m_rd    = instruct[15:11];
            if (flush || m_hz || !valid_in) begin
               m_ctl   = 14'h0;
               m_valid = 1'b0;
            end else begin
               m_ctl   = ref_decode(instruct);
               m_valid = 1'b1;
            end
         end
         if (wb_reg_write && wb_reg != 5'd0) m_rf[wb_reg] = wb_data;
      end
   end

   // Compare process: every falling edge, DUT against model
   always @(negedge clk) begin
      check("hazard_stall", 32'(hazard_stall), 32'(ref_hazard()));
      check("mem1Read", mem1Read, m_m1);
      check("mem2Read", mem2Read, m_m2);
      check("signExnd", signExnd, m_sx);
      check("address_ex", address_ex, m_addr);
      check("instruct_ex", instruct_ex, m_instr);
      check("rt_ex", 32'(rt_ex), 32'(m_rt));
      check("rd_ex", 32'(rd_ex), 32'(m_rd));
      check("controls", 32'({ALUSrc, Branch, RegDst, RegWrite, MemRead, MemWrite,
                              MemtoReg, ALUOp, FunctC, illegal_op}), 32'(m_ctl));
      check("valid_ex", 32'(valid_ex), 32'(m_valid));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_in = 0; stall = 0; flush = 0; wb_reg_write = 0; wb_reg = 0; wb_data = 0;
      instruct = 0; address = 0;
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      tick(); tick();
      check("lit_reset_addr", address_ex, 32'h0);
      check("lit_reset_valid", 32'(valid_ex), 32'h0);
      check("lit_reset_m1", mem1Read, 32'h0);

      // ADD immediate
      rst_n = 1; instruct = 32'h40000177; address = 32'd4; valid_in = 1;
      tick();
      check("lit_add_alusrc", 32'(ALUSrc), 32'h1);
      check("lit_add_aluop", 32'(ALUOp), 32'h1);
      check("lit_add_funct", 32'(FunctC), 32'h2);
      check("lit_add_sx", signExnd, 32'h00000177);
      check("lit_add_addr", address_ex, 32'd4);
      check("lit_add_valid", 32'(valid_ex), 32'h1);

      // r5, r6 then BEQ
      valid_in = 0; wb_reg_write = 1; wb_reg = 5; wb_data = 32'h2D750177; tick();
      wb_reg = 6; tick();
      wb_reg_write = 0; valid_in = 1; instruct = 32'h10A6000A; address = 32'd8;
      tick();
      check("lit_beq_branch", 32'(Branch), 32'h1);
      check("lit_beq_aluop", 32'(ALUOp), 32'h0);
      check("lit_beq_funct", 32'(FunctC), 32'h4);
      check("lit_beq_m1", mem1Read, 32'h2D750177);
      check("lit_beq_m2", mem2Read, 32'h2D750177);
      check("lit_beq_sx", signExnd, 32'd10);

      // write-through on rs=7, then r0 write ignored
      instruct = 32'h00E05020; wb_reg_write = 1; wb_reg = 7; wb_data = 32'h12345678;
      tick();
      check("lit_wt_m1", mem1Read, 32'h12345678);
      instruct = 32'h00005020; wb_reg = 0; wb_data = 32'hFFFFFFFF;
      tick();
      wb_reg_write = 0;
      tick();
      check("lit_r0_m1", mem1Read, 32'h0);
      check("lit_r0_m2", mem2Read, 32'h0);

      // LW r8 then dependent R-type: one bubble
      instruct = 32'h8C280000; tick();
      check("lit_lw_memread", 32'(MemRead), 32'h1);
      instruct = 32'h01084820; #1;
      check("lit_hz_on", 32'(hazard_stall), 32'h1);
      tick();
      check("lit_bubble_valid", 32'(valid_ex), 32'h0);
      check("lit_hz_off", 32'(hazard_stall), 32'h0);
      tick();
      check("lit_rtype_valid", 32'(valid_ex), 32'h1);
      check("lit_rtype_regdst", 32'(RegDst), 32'h1);
      check("lit_rtype_instr", instruct_ex, 32'h01084820);

      // stall holds for 3 cycles, then flush wins over stall
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         instruct = $urandom; address = $urandom;
         tick();
         check("lit_stall_instr", instruct_ex, 32'h01084820);
         check("lit_stall_regdst", 32'(RegDst), 32'h1);
      end
      flush = 1; instruct = 32'h40000001;
      tick();
      check("lit_flush_valid", 32'(valid_ex), 32'h0);
      check("lit_flush_instr", instruct_ex, 32'h40000001);
      check("lit_flush_alusrc", 32'(ALUSrc), 32'h0);

      // illegal opcode, negative immediate
      flush = 0; stall = 0; instruct = 32'hFC008000;
      tick();
      check("lit_ill_flag", 32'(illegal_op), 32'h1);
      check("lit_ill_regwrite", 32'(RegWrite), 32'h0);
      check("lit_ill_valid", 32'(valid_ex), 32'h1);
      check("lit_ill_sx", signExnd, 32'hFFFF8000);

      // reset during stall discards the pending write-back
      valid_in = 0; wb_reg_write = 1; wb_reg = 3; wb_data = 32'hAA; tick();
      rst_n = 0; stall = 1; wb_data = 32'hBB; tick();
      rst_n = 1; stall = 0; wb_reg_write = 0; valid_in = 1; instruct = 32'h00600000;
      tick();
      check("lit_rst_rf_clear", mem1Read, 32'h0);

      // randomized traffic over a small register set to provoke hazards
      for (int n = 0; n < 1500; n++) begin
         logic [5:0] op;
         case ($urandom_range(0, 6))
            0: op = 6'h00; 1: op = 6'h10; 2: op = 6'h23; 3: op = 6'h23;
            4: op = 6'h2B; 5: op = 6'h04; default: op = 6'($urandom);
         endcase
         instruct     = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         address      = $urandom;
         rst_n        = ($urandom_range(0, 199) != 0);
         valid_in     = ($urandom_range(0, 5) != 0);
         stall        = ($urandom_range(0, 7) == 0);
         flush        = ($urandom_range(0, 9) == 0);
         wb_reg_write = ($urandom_range(0, 1) != 0);
         wb_reg       = 5'($urandom_range(0, 7));
         wb_data      = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage plus ID/EX pipeline register, directly upstream of the Execute stage. Decodes the fetched instruction, reads two operands from an internal 32x32 register file, sign-extends the immediate and registers everything Execute consumes: mem1Read, mem2Read, signExnd, address, instruct, ALUSrc, Branch, FunctC and ALUOp. It also accepts the write-back port, detects load-use hazards and supports downstream stall and branch flush.

## Interface
- RESET_PC, 32'h0: value of address_ex after reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- instruct  in  32  instruction from IF/ID.
- address  in  32  PC+4 from IF/ID.
- valid_in  in  1  IF/ID slot holds a real instruction.
- stall  in  1  downstream hold; ID/EX keeps its contents.
- flush  in  1  taken branch; ID/EX loads a bubble.
- wb_reg_write  in  1  write-back enable.
- wb_reg  in  5  write-back destination.
- wb_data  in  32  write-back data.
- hazard_stall  out  1  combinational; fetch must hold PC and IF/ID.
- mem1Read, mem2Read  out  32  rs and rt operands.
- signExnd  out  32  sign-extended instruct[15:0].
- address_ex, instruct_ex  out  32  pipelined PC+4 and instruction.
- rt_ex, rd_ex  out  5  destination candidates.
- ALUSrc, Branch, RegDst, RegWrite, MemRead, MemWrite, MemtoReg  out  1  control.
- ALUOp  out  2;  FunctC  out  4  ALU control.
- valid_ex  out  1  ID/EX holds a real instruction.
- illegal_op  out  1  registered; the decoded opcode is unsupported.

## Operation
- Decode on opcode instruct[31:26]. Any field not listed is 0:
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=10, FunctC=instruct[3:0].
  - 010000 ADD: ALUSrc=1, RegWrite=1, ALUOp=01, FunctC=0010.
  - 100011 LW: ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, ALUOp=01, FunctC=0010.
  - 101011 SW: ALUSrc=1, MemWrite=1, ALUOp=01, FunctC=0010.
  - 000100 BEQ: Branch=1, ALUOp=00, FunctC=0100.
  - Other opcodes: all controls 0 and illegal_op=1. The instruction still propagates with valid_ex=1.
- valid_in=0: controls are forced to 0 and illegal_op=0.
- Register file:
  - r0 reads 0 and ignores writes.
  - Write is synchronous on clk when wb_reg_write=1 and wb_reg!=0.
  - Reads are combinational with write-through: if wb_reg matches rs (rt), the read returns wb_data in the same cycle.
- Sign extension: signExnd = {{16{instruct[15]}}, instruct[15:0]}.
- Load-use hazard: hazard_stall = valid_in & valid_ex & MemRead & (rt_ex!=0) & (rt_ex==instruct[25:21] | (rt_ex==instruct[20:16] & opcode in {000000, 101011, 000100})).

## Timing
- ID/EX update priority on each rising edge:
  1. Reset: all outputs 0, except address_ex=RESET_PC. Register file cleared to 0.
  2. flush: bubble (controls 0, valid_ex=0, illegal_op=0). Data fields take the new values.
  3. stall: hold every ID/EX field. The register-file write still occurs.
  4. hazard_stall: bubble, as for flush.
  5. Otherwise: load the decoded values.
- Latency: one cycle from instruct/address to the ID/EX outputs.
- A load followed by a dependent instruction costs exactly one bubble. hazard_stall deasserts in the next cycle because valid_ex=0.
- stall and flush together: flush wins.
- Reset asserted mid-stall clears everything. A pending write-back in that cycle is discarded.

## Structure
- Shared package mips_defs holds:
  - opcode constants (OP_RTYPE, OP_ADD, OP_LW, OP_SW, OP_BEQ);
  - ALUOp codes (00, 01, 10);
  - FunctC codes (0010 add, 0100 compare).
- Sub-module reg_file: 32x32, two async read ports with write-through, one sync write port, sync active-low clear.
- Decode logic, hazard logic and the ID/EX register stay in decode_stage.

## Test plan
- Reset, then instruct=32'h40000177, address=4 → next cycle: ALUSrc=1, ALUOp=01, FunctC=0010, signExnd=32'h00000177, address_ex=4, valid_ex=1.
- Write r5=32'h2D750177 and r6=32'h2D750177, then BEQ r5,r6,+10 (32'h10A6000A) → Branch=1, ALUOp=00, FunctC=0100, mem1Read=mem2Read=32'h2D750177, signExnd=10.
- wb_reg=7, wb_data=32'h12345678 in the same cycle as an R-type reading rs=7 → mem1Read=32'h12345678 (write-through). A write to r0 → r0 still reads 0.
- LW r8,0(r1) followed by ADD r9=r8+r8 (R-type) → hazard_stall=1 for exactly one cycle, one bubble with valid_ex=0, then the R-type issues.
- stall=1 for 3 cycles with changing instruct → ID/EX outputs constant. flush=1 together with stall → bubble loaded.
- Opcode 111111 → illegal_op=1, all controls 0. signExnd for imm 16'h8000 = 32'hFFFF8000.
